// File: rtl/modulo_counter_pkg.sv
// Shared constants and next-count rule for the modulo counter.
// next_count() is used by the RTL and available to verification models.
package modulo_counter_pkg;

    // Widest counter next_count() can serve; callers zero-extend.
    localparam int CNT_W = 32;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns {wrap, next}.
    // Up: a count at or beyond the terminal folds back to zero and wraps.
    // Down: zero reloads the terminal and wraps.
    //       An out-of-range value snaps to the terminal without wrapping.
    function automatic logic [CNT_W:0] next_count(
        input logic [CNT_W-1:0] q,
        input logic [CNT_W-1:0] term,
        input logic             up
    );
        logic [CNT_W:0] r;
        if (up == DIR_UP) begin
            if (q >= term) r = {1'b1, {CNT_W{1'b0}}};
            else           r = {1'b0, q + 1'b1};
        end else begin
            if (q == '0)       r = {1'b1, term};
            else if (q > term) r = {1'b0, term};
            else               r = {1'b0, q - 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/modulo_counter_window_compare.sv
// Half-open window test: start <= value < end, unsigned.
// Ports: value_i, start_i, end_i in; in_win_o out (0 when start >= end).
module window_compare #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] start_i,
    input  logic [WIDTH-1:0] end_i,
    output logic             in_win_o
);

    assign in_win_o = (value_i >= start_i) && (value_i < end_i);

endmodule

// File: rtl/modulo_counter.sv
// Cascadable programmable modulo counter for the HDMI TX timing chain.
// Ports: clock, MR (async reset), SCLR, PE_n/Dn load, CEP/CET enables,
//        UP, TERM, WIN_START/WIN_END in; Qn_out, TC_out, WRAP_out, WIN_out out.
module modulo_counter
    import modulo_counter_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             MR,
    input  logic             SCLR,
    input  logic             PE_n,
    input  logic [WIDTH-1:0] Dn,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UP,
    input  logic [WIDTH-1:0] TERM,
    input  logic [WIDTH-1:0] WIN_START,
    input  logic [WIDTH-1:0] WIN_END,
    output logic [WIDTH-1:0] Qn_out,
    output logic             TC_out,
    output logic             WRAP_out,
    output logic             WIN_out
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             win_q, win_d;
    logic             rst_q;
    logic             win_rst;
    logic [CNT_W:0]   nc;
    logic             unused_nc;

    assign nc = next_count(CNT_W'(q_q), CNT_W'(TERM), UP);
    assign unused_nc = ^nc;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (SCLR) begin
            q_d = RESET_VALUE;
        end else if (!PE_n) begin
            q_d = Dn;
        end else if (CEP && CET) begin
            q_d    = nc[WIDTH-1:0];
            wrap_d = nc[CNT_W];
        end
    end

    // Window flag is computed on the next-state count so it
    // lands in the same cycle as the count it describes.
    window_compare #(.WIDTH(WIDTH)) u_win_next (
        .value_i  (q_d),
        .start_i  (WIN_START),
        .end_i    (WIN_END),
        .in_win_o (win_d)
    );

    // Until the first edge after reset there is no registered flag,
    // so the reset count is compared directly.
    window_compare #(.WIDTH(WIDTH)) u_win_rst (
        .value_i  (RESET_VALUE),
        .start_i  (WIN_START),
        .end_i    (WIN_END),
        .in_win_o (win_rst)
    );

    always_ff @(posedge clock or posedge MR) begin
        if (MR) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
            win_q  <= 1'b0;
            rst_q  <= 1'b1;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            win_q  <= win_d;
            rst_q  <= 1'b0;
        end
    end

    assign Qn_out   = q_q;
    assign WRAP_out = wrap_q;
    assign WIN_out  = rst_q ? win_rst : win_q;

    // Carry-out ignores CEP so a paused low stage still gates the next.
    assign TC_out = CET && ((UP == DIR_UP) ? (q_q >= TERM) : (q_q == '0));

endmodule

// File: tb/tb_modulo_counter.sv
// Directed bench for modulo_counter with a per-cycle arithmetic model.
// Also checks a two-stage cascade against a flat cycle count.
module tb_modulo_counter;

    logic       clock = 1'b0;
    logic       MR = 1'b1;
    logic       SCLR = 1'b0;
    logic       PE_n = 1'b1;
    logic [7:0] Dn = 8'd0;
    logic       CEP = 1'b1;
    logic       CET = 1'b1;
    logic       UP = 1'b1;
    logic [7:0] TERM = 8'd250;
    logic [7:0] WS = 8'd10;
    logic [7:0] WE = 8'd20;
    logic [7:0] Qn;
    logic       TC, WRAP, WIN;

    logic       cMR = 1'b1;
    logic [7:0] s0, s1;
    logic       tc0, tc1;
    logic       unused_w0, unused_w1, unused_r0, unused_r1;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;

    modulo_counter #(.WIDTH(8), .RESET_VALUE(8'd0)) dut (
        .clock(clock), .MR(MR), .SCLR(SCLR), .PE_n(PE_n), .Dn(Dn),
        .CEP(CEP), .CET(CET), .UP(UP), .TERM(TERM),
        .WIN_START(WS), .WIN_END(WE),
        .Qn_out(Qn), .TC_out(TC), .WRAP_out(WRAP), .WIN_out(WIN)
    );

    modulo_counter #(.WIDTH(8), .RESET_VALUE(8'd0)) st0 (
        .clock(clock), .MR(cMR), .SCLR(1'b0), .PE_n(1'b1), .Dn(8'd0),
        .CEP(1'b1), .CET(1'b1), .UP(1'b1), .TERM(8'd3),
        .WIN_START(8'd0), .WIN_END(8'd0),
        .Qn_out(s0), .TC_out(tc0), .WRAP_out(unused_r0), .WIN_out(unused_w0)
    );

    modulo_counter #(.WIDTH(8), .RESET_VALUE(8'd0)) st1 (
        .clock(clock), .MR(cMR), .SCLR(1'b0), .PE_n(1'b1), .Dn(8'd0),
        .CEP(1'b1), .CET(tc0), .UP(1'b1), .TERM(8'd3),
        .WIN_START(8'd0), .WIN_END(8'd0),
        .Qn_out(s1), .TC_out(tc1), .WRAP_out(unused_r1), .WIN_out(unused_w1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Counting modulo TERM+1, written as remainder arithmetic.
    function automatic logic [8:0] model_next(
        input logic [7:0] q, input logic [7:0] t, input logic up
    );
        int qi, ti, n;
        qi = int'(q);
        ti = int'(t);
        if (up) begin
            if (qi > ti) return 9'h100;
            n = (qi + 1) % (ti + 1);
            return {n == 0, 8'(n)};
        end
        if (qi > ti) return {1'b0, t};
        n = (qi + ti) % (ti + 1);
        return {qi == 0, 8'(n)};
    endfunction

    function automatic logic in_win(input logic [7:0] v, s, e);
        return (int'(v) >= int'(s)) && (int'(v) < int'(e));
    endfunction

    logic [7:0] mq = 8'd0;
    logic       mw = 1'b0;
    logic       mwin = 1'b0;
    logic [7:0] m_nx;
    logic       m_nw;

    always_comb begin
        m_nx = mq;
        m_nw = 1'b0;
        if (SCLR) m_nx = 8'd0;
        else if (!PE_n) m_nx = Dn;
        else if (CEP && CET) {m_nw, m_nx} = model_next(mq, TERM, UP);
    end

    always @(posedge clock or posedge MR) begin
        if (MR) begin
            mq   <= 8'd0;
            mw   <= 1'b0;
            mwin <= in_win(8'd0, WS, WE);
        end else begin
            mq   <= m_nx;
            mw   <= m_nw;
            mwin <= in_win(m_nx, WS, WE);
        end
    end

    always @(negedge clock) begin
        if (chk_en && !MR) begin
            chk("model_q", int'(Qn), int'(mq));
            chk("model_wrap", int'(WRAP), int'(mw));
            chk("model_win", int'(WIN), int'(mwin));
            chk("model_tc", int'(TC),
                int'(CET && (UP ? (mq >= TERM) : (mq == 8'd0))));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin : main
        int ex[5];
        ex = '{2, 1, 0, 9, 8};

        #1;
        chk("reset_q", int'(Qn), 0);
        chk("reset_wrap", int'(WRAP), 0);
        chk("reset_win", int'(WIN), 0);
        tick();
        tick();
        MR = 1'b0;
        chk_en = 1'b1;

        // Up count TERM=250
        repeat (250) tick();
        chk("up_q250", int'(Qn), 250);
        chk("up_tc250", int'(TC), 1);
        tick();
        chk("up_wrap_q", int'(Qn), 0);
        chk("up_wrap_pulse", int'(WRAP), 1);
        tick();
        chk("up_after_q", int'(Qn), 1);
        chk("up_after_wrap", int'(WRAP), 0);

        // Empty window
        WS = 8'd20;
        WE = 8'd10;
        repeat (15) tick();
        chk("empty_q", int'(Qn), 16);
        chk("empty_win", int'(WIN), 0);
        WS = 8'd10;
        WE = 8'd20;
        tick();
        chk("win_q17", int'(WIN), 1);

        // Down count TERM=9 from load 3
        UP = 1'b0;
        TERM = 8'd9;
        PE_n = 1'b0;
        Dn = 8'd3;
        tick();
        PE_n = 1'b1;
        chk("down_load", int'(Qn), 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("down_seq", int'(Qn), ex[i]);
            if (ex[i] == 0) chk("down_tc0", int'(TC), 1);
            if (ex[i] == 9) chk("down_wrap9", int'(WRAP), 1);
        end

        // Out-of-range load
        UP = 1'b1;
        TERM = 8'd100;
        WS = 8'd195;
        WE = 8'd205;
        PE_n = 1'b0;
        Dn = 8'd200;
        tick();
        PE_n = 1'b1;
        chk("oor_load", int'(Qn), 200);
        chk("oor_win", int'(WIN), 1);
        chk("oor_tc", int'(TC), 1);
        tick();
        chk("oor_up_q", int'(Qn), 0);
        chk("oor_up_wrap", int'(WRAP), 1);
        UP = 1'b0;
        PE_n = 1'b0;
        tick();
        PE_n = 1'b1;
        chk("oor_dn_tc", int'(TC), 0);
        tick();
        chk("oor_dn_q", int'(Qn), 100);
        chk("oor_dn_wrap", int'(WRAP), 0);
        WS = 8'd10;
        WE = 8'd20;

        // Async MR at 57
        UP = 1'b1;
        TERM = 8'd250;
        PE_n = 1'b0;
        Dn = 8'd50;
        tick();
        PE_n = 1'b1;
        repeat (7) tick();
        chk("mr_pre_q", int'(Qn), 57);
        #1 MR = 1'b1;
        #1;
        chk("mr_async_q", int'(Qn), 0);
        chk("mr_async_wrap", int'(WRAP), 0);
        tick();
        MR = 1'b0;

        // Clear beats load
        repeat (3) tick();
        chk("pre_clr_q", int'(Qn), 3);
        SCLR = 1'b1;
        PE_n = 1'b0;
        Dn = 8'd5;
        tick();
        SCLR = 1'b0;
        PE_n = 1'b1;
        chk("clr_wins", int'(Qn), 0);

        // Hold
        repeat (2) tick();
        TERM = 8'd2;
        CEP = 1'b0;
        repeat (3) tick();
        chk("hold_q", int'(Qn), 2);
        chk("hold_tc_cet1", int'(TC), 1);
        CET = 1'b0;
        #1;
        chk("hold_tc_cet0", int'(TC), 0);

        // TERM=0 back-to-back wraps
        CEP = 1'b1;
        CET = 1'b1;
        TERM = 8'd0;
        repeat (2) tick();
        chk("term0_wrap_a", int'(WRAP), 1);
        tick();
        chk("term0_wrap_b", int'(WRAP), 1);

        // Cascade
        tick();
        cMR = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk("casc_s0", int'(s0), n % 4);
            chk("casc_s1", int'(s1), (n / 4) % 4);
            chk("casc_tc1", int'(tc1), int'((n % 16) == 15));
        end
        chk("casc_full", int'({s1, s0}), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
